seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Parametrised multiplexed seven-segment display driver for the board's common-anode digit bank. It snapshots an N-digit BCD/hex word once per frame and time-multiplexes the anodes. Each digit slot has an anti-ghosting blank gap. It supports leading-zero suppression, per-digit blanking and decimal points, and an optional hex glyph set. It sits between game/score logic and the board pins, replacing per-digit combinational decoders.

Parameters:
NUM_DIGITS, 4, number of digits/anodes driven (1..8)
SCAN_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); must be > BLANK_CYCLES
BLANK_CYCLES, 2000, cycles at the start of each slot with all anodes off
HEX_MODE, 0, 0 = legacy glyph set, 1 = hex glyphs A-F for codes 10-15

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
enable  in  1  1 = scan; 0 = display dark
digits_in  in  4*NUM_DIGITS  digit i code at [4i+3:4i]; digit 0 = rightmost
dp_in  in  NUM_DIGITS  1 = light decimal point of digit i
blank_in  in  NUM_DIGITS  1 = force digit i fully dark, including dp
lz_suppress  in  1  1 = suppress leading zeros
anode  out  NUM_DIGITS  active-low digit enables
cathode  out  8  active-low segments {a,b,c,d,e,f,g,dp}, dp = bit 0
frame_tick  out  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Reset (async, any time): anode = all 1s, cathode = 8'hFF, frame_tick = 0, slot counter = 0, digit index = 0, shadow registers = 0, FSM = IDLE.
- All outputs are registered. Any input change reaches the pins no earlier than the next snapshot.
- FSM states:
  - IDLE: dark, counters held at 0. Go to BLANK when enable = 1.
  - BLANK: anode all 1s, cathode FF for BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: anode[idx] = 0, others 1, cathode = glyph of idx. Stays until slot count reaches SCAN_DIV-1, then idx increments (wrapping N-1 -> 0) and FSM returns to BLANK.
- Snapshot: on entry to BLANK with idx = 0, from IDLE or from wrap, latch digits_in, dp_in, blank_in and lz_suppress into shadow registers. frame_tick = 1 for that cycle only. Mid-frame input changes are invisible until the next frame.
- Frame period = NUM_DIGITS*SCAN_DIV cycles. The slot counter is $clog2(SCAN_DIV) bits and restarts at 0 each slot.
- enable = 0 in any state: next cycle goes to IDLE (dark), idx = 0. Re-enable starts a fresh frame with a new snapshot.
- Glyph table, shared with legacy decode:
  - 0-9: 03,9F,25,0D,99,49,41,1F,01,09 (hex, dp off).
  - HEX_MODE = 0: 10 = FE (dp segment only), 11 = 31 ('P'), 12-15 = FF.
  - HEX_MODE = 1: 10-15 = 11,C1,63,85,61,71 (A,b,C,d,E,F).
- Leading zeros: digit i (i > 0) is suppressed when the shadow lz is set, its code is 0, and all higher digits' codes are 0. A suppressed digit has segments a-g off; dp still follows dp_in. Digit 0 is never suppressed.
- Decimal point: dp_in[i] = 1 clears cathode bit 0 on top of the glyph.
- Priority per digit: blank_in > suppression > glyph; dp_in applies to all except blank_in.
- Width rule: digits_in width is exactly 4*NUM_DIGITS; there is no truncation.

Decomposition:
- Package seg7_pkg: 8-bit glyph constants (SEG_0..SEG_9, SEG_DP, SEG_P, SEG_A..SEG_F, SEG_OFF = 8'hFF), FSM state enum {IDLE, BLANK, DRIVE}.
- Sub-module seg_glyph_decode (combinational): 4-bit code + hex_mode -> 8-bit cathode pattern. The scanner instantiates one copy on the current shadow digit.

Test Plan:
1. Reset asserted mid-DRIVE with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 -> same cycle anode = 4'hF, cathode = 8'hFF, frame_tick = 0. After release with enable = 1, frame_tick pulses once.
2. digits_in = 16'h1234, enable = 1 -> per slot: 2 cycles dark, then 6 cycles with anode = 1110 / cathode 0x99, anode = 1101 / 0x0D, 1011 / 0x25, 0111 / 0x9F. frame_tick every 32 cycles.
3. digits_in = 16'h0050, lz_suppress = 1, dp_in = 4'b0100 -> digit 3 FF, digit 2 FE (dp only), digit 1 0x49, digit 0 0x03.
4. Change digits_in from 16'h1234 to 16'h9999 during slot 1 -> slots 1-3 still show 3,2,1. Next frame shows 9 (0x09) on all digits.
5. HEX_MODE = 1, digits_in = 16'hABCD, blank_in = 4'b1000 -> digit 3 FF, digit 2 0xC1, digit 1 0x63, digit 0 0x85. With HEX_MODE = 0, code B gives 0x31.
6. enable dropped during slot 2 -> next cycle dark. Re-enable -> BLANK of slot 0 with frame_tick = 1 and a fresh snapshot.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared glyph constants and scan FSM state type for the
//                multiplexed seven-segment driver. Segment order is
//                {a,b,c,d,e,f,g,dp}, active-low, dp in bit 0.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [7:0] SEG_0   = 8'h03;
    localparam logic [7:0] SEG_1   = 8'h9F;
    localparam logic [7:0] SEG_2   = 8'h25;
    localparam logic [7:0] SEG_3   = 8'h0D;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h49;
    localparam logic [7:0] SEG_6   = 8'h41;
    localparam logic [7:0] SEG_7   = 8'h1F;
    localparam logic [7:0] SEG_8   = 8'h01;
    localparam logic [7:0] SEG_9   = 8'h09;
    localparam logic [7:0] SEG_DP  = 8'hFE;
    localparam logic [7:0] SEG_P   = 8'h31;
    localparam logic [7:0] SEG_A   = 8'h11;
    localparam logic [7:0] SEG_B   = 8'hC1;
    localparam logic [7:0] SEG_C   = 8'h63;
    localparam logic [7:0] SEG_D   = 8'h85;
    localparam logic [7:0] SEG_E   = 8'h61;
    localparam logic [7:0] SEG_F   = 8'h71;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg_glyph_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg_glyph_decode
//  Description : Combinational 4-bit code to active-low cathode pattern.
//                hex_mode selects A-F glyphs for codes 10-15 instead of the
//                legacy dp-only / 'P' / dark glyphs.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_glyph_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output logic [7:0] segments
);

    // Glyph lookup; codes 10-15 depend on the selected glyph set
    always_comb begin
        segments = SEG_OFF;
        case (code)
            4'd0:  segments = SEG_0;
            4'd1:  segments = SEG_1;
            4'd2:  segments = SEG_2;
            4'd3:  segments = SEG_3;
            4'd4:  segments = SEG_4;
            4'd5:  segments = SEG_5;
            4'd6:  segments = SEG_6;
            4'd7:  segments = SEG_7;
            4'd8:  segments = SEG_8;
            4'd9:  segments = SEG_9;
            4'd10: segments = hex_mode ? SEG_A : SEG_DP;
            4'd11: segments = hex_mode ? SEG_B : SEG_P;
            4'd12: segments = hex_mode ? SEG_C : SEG_OFF;
            4'd13: segments = hex_mode ? SEG_D : SEG_OFF;
            4'd14: segments = hex_mode ? SEG_E : SEG_OFF;
            4'd15: segments = hex_mode ? SEG_F : SEG_OFF;
            default: segments = SEG_OFF;
        endcase
    end

endmodule : seg_glyph_decode
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scanner
//  Description : Multiplexed common-anode seven-segment driver. Snapshots the
//                digit word once per frame, scans one digit per slot with a
//                dark anti-ghosting gap at the start of each slot, and applies
//                blanking, leading-zero suppression and decimal points.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode,
    output logic                    frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // A zero-length gap is treated as one dark cycle so BLANK is always visited
    localparam int C_BLANK_EFF = (BLANK_CYCLES > 0) ? BLANK_CYCLES : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(C_BLANK_EFF - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic             C_HEX        = (HEX_MODE != 0);

    scan_state_t               r_state;
    scan_state_t               w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [IDX_W-1:0]          r_idx;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic                      w_snap;

    logic [4*NUM_DIGITS-1:0]   r_digits;
    logic [NUM_DIGITS-1:0]     r_dp;
    logic [NUM_DIGITS-1:0]     r_blank;
    logic                      r_lz;

    logic [NUM_DIGITS-1:0]     r_anode;
    logic [7:0]                r_cathode;
    logic                      r_tick;

    logic                      w_zero_run;
    logic [NUM_DIGITS-1:0]     w_lz_mask;
    logic [3:0]                w_code;
    logic                      w_sel_dp;
    logic                      w_sel_blank;
    logic                      w_sel_lz;
    logic [NUM_DIGITS-1:0]     w_anode_drive;
    logic [7:0]                w_glyph;
    logic [7:0]                w_cathode_drive;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, slot counter / digit index advance and snapshot request
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_snap      = 1'b0;
        if (!enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_snap      = 1'b1;
                end
                BLANK: begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == C_BLANK_LAST) begin
                        w_state_nxt = DRIVE;
                    end
                end
                DRIVE: begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_state_nxt = BLANK;
                        w_cnt_nxt   = '0;
                        if (r_idx == C_IDX_LAST) begin
                            w_idx_nxt = '0;
                            w_snap    = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Slot counter and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_idx <= w_idx_nxt;
        end
    end

    // Frame snapshot of all display inputs; frozen for the rest of the frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digits <= '0;
            r_dp     <= '0;
            r_blank  <= '0;
            r_lz     <= 1'b0;
        end else if (w_snap) begin
            r_digits <= digits_in;
            r_dp     <= dp_in;
            r_blank  <= blank_in;
            r_lz     <= lz_suppress;
        end
    end

    // Leading-zero mask: walk down from the top digit while codes stay zero
    always_comb begin
        w_zero_run = 1'b1;
        w_lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run   = w_zero_run && (r_digits[4*i +: 4] == 4'd0);
            w_lz_mask[i] = r_lz && w_zero_run && (i != 0);
        end
    end

    // Select the shadow attributes of the digit currently being scanned
    always_comb begin
        w_code        = 4'd0;
        w_sel_dp      = 1'b0;
        w_sel_blank   = 1'b0;
        w_sel_lz      = 1'b0;
        w_anode_drive = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_code           = r_digits[4*i +: 4];
                w_sel_dp         = r_dp[i];
                w_sel_blank      = r_blank[i];
                w_sel_lz         = w_lz_mask[i];
                w_anode_drive[i] = 1'b0;
            end
        end
    end

    seg_glyph_decode u_glyph (
        .code     (w_code),
        .hex_mode (C_HEX),
        .segments (w_glyph)
    );

    // Cathode priority: blank beats everything, suppression keeps the dp
    always_comb begin
        w_cathode_drive = w_sel_lz ? SEG_OFF : w_glyph;
        if (w_sel_dp) begin
            w_cathode_drive[0] = 1'b0;
        end
        if (w_sel_blank) begin
            w_cathode_drive = SEG_OFF;
        end
    end

    // Registered pins, aligned with the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_anode   <= '1;
            r_cathode <= SEG_OFF;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_snap;
            if (w_state_nxt == DRIVE) begin
                r_anode   <= w_anode_drive;
                r_cathode <= w_cathode_drive;
            end else begin
                r_anode   <= '1;
                r_cathode <= SEG_OFF;
            end
        end
    end

    assign anode      = r_anode;
    assign cathode    = r_cathode;
    assign frame_tick = r_tick;

endmodule : seven_seg_scanner
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scanner
//  Description : Self-checking bench for seven_seg_scanner. Two instances
//                (legacy and hex glyphs) share stimulus; a frame-position
//                reference model predicts anode/cathode/frame_tick each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

    localparam int N     = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * SD;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_suppress;

    logic [3:0]  anode0, anode1;
    logic [7:0]  cath0, cath1;
    logic        tick0, tick1;

    int checks = 0;
    int errors = 0;

    // Reference model state: running flag, position in frame, frame snapshot
    bit          m_run = 1'b0;
    int          m_pos = 0;
    logic [15:0] s_dig = '0;
    logic [3:0]  s_dp = '0;
    logic [3:0]  s_blank = '0;
    logic        s_lz = 1'b0;

    logic [7:0] tbl_leg [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'hFE, 8'h31, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] tbl_hex [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .HEX_MODE(0)
    ) u_dut_leg (
        .clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in),
        .dp_in(dp_in), .blank_in(blank_in), .lz_suppress(lz_suppress),
        .anode(anode0), .cathode(cath0), .frame_tick(tick0)
    );

    seven_seg_scanner #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .HEX_MODE(1)
    ) u_dut_hex (
        .clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in),
        .dp_in(dp_in), .blank_in(blank_in), .lz_suppress(lz_suppress),
        .anode(anode1), .cathode(cath1), .frame_tick(tick1)
    );

    function automatic logic [7:0] exp_cath(int d, bit hex);
        logic [3:0] code;
        logic [7:0] c;
        code = s_dig[4*d +: 4];
        if (s_blank[d]) return 8'hFF;
        if (s_lz && d > 0 && (s_dig >> (4 * d)) == 16'h0) c = 8'hFF;
        else c = hex ? tbl_hex[code] : tbl_leg[code];
        if (s_dp[d]) c[0] = 1'b0;
        return c;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h frame_pos=%0d t=%0t", tag, obs, exp, m_pos, $time);
        end
    endtask

    task automatic compare_all();
        logic [3:0] ea;
        logic [7:0] ec0, ec1;
        logic       et;
        int         slot;
        ea = 4'hF; ec0 = 8'hFF; ec1 = 8'hFF; et = 1'b0;
        if (m_run) begin
            slot = m_pos / SD;
            et   = (m_pos == 0);
            if ((m_pos % SD) >= BC) begin
                ea  = ~(4'b0001 << slot);
                ec0 = exp_cath(slot, 1'b0);
                ec1 = exp_cath(slot, 1'b1);
            end
        end
        chk("anode_leg",   {4'h0, anode0}, {4'h0, ea});
        chk("anode_hex",   {4'h0, anode1}, {4'h0, ea});
        chk("cathode_leg", cath0, ec0);
        chk("cathode_hex", cath1, ec1);
        chk("tick_leg",    {7'h0, tick0}, {7'h0, et});
        chk("tick_hex",    {7'h0, tick1}, {7'h0, et});
    endtask

    task automatic snap();
        s_dig   = digits_in;
        s_dp    = dp_in;
        s_blank = blank_in;
        s_lz    = lz_suppress;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check
    task automatic step();
        @(posedge clk);
        if (reset || !enable) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_pos = 0;
            snap();
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            if (m_pos == 0) snap();
        end
        #1;
        compare_all();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic wait_pos(int target);
        int guard;
        guard = 0;
        while (!(m_run && m_pos == target) && guard < 4 * FRAME) begin
            step();
            guard++;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; digits_in = 16'h0; dp_in = 4'h0;
        blank_in = 4'h0; lz_suppress = 1'b0;
        #12;
        compare_all();
        run(2);

        // Plain scan of 1234
        reset = 1'b0; enable = 1'b1; digits_in = 16'h1234;
        run(3 * FRAME);

        // Asynchronous reset in the middle of a DRIVE slot
        wait_pos(SD + 4);
        #3;
        reset = 1'b1;
        #1;
        m_run = 1'b0;
        compare_all();
        run(2);
        reset = 1'b0;
        run(FRAME + 2);

        // Leading-zero suppression with a decimal point on a suppressed digit
        digits_in = 16'h0050; lz_suppress = 1'b1; dp_in = 4'b0100;
        run(2 * FRAME);

        // Mid-frame change is invisible until the next snapshot
        digits_in = 16'h1234; lz_suppress = 1'b0; dp_in = 4'b0000;
        wait_pos(1);
        wait_pos(SD + 3);
        digits_in = 16'h9999;
        run(2 * FRAME);

        // Hex glyphs with the top digit blanked; legacy instance shows 'P' for B
        digits_in = 16'hABCD; blank_in = 4'b1000;
        wait_pos(1);
        run(FRAME + 4);

        // Drop enable during slot 2, then restart with a fresh snapshot
        blank_in = 4'b0000; digits_in = 16'h4321;
        wait_pos(2 * SD + 3);
        enable = 1'b0;
        run(5);
        digits_in = 16'h0765;
        enable = 1'b1;
        run(FRAME + 3);

        // Randomised frames with occasional enable drops and mid-frame changes
        for (int k = 0; k < 40; k++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            digits_in   = 16'($urandom) & mask;
            dp_in       = 4'($urandom);
            blank_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lz_suppress = 1'($urandom);
            run($urandom_range(5, 70));
            if ($urandom_range(0, 5) == 0) begin
                enable = 1'b0;
                run($urandom_range(1, 3));
                enable = 1'b1;
            end
        end
        run(FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seven_seg_scanner
`default_nettype wire
